// File: rtl/pwl_activation_pipe_pkg.sv
// Shared definitions for the piecewise-linear activation unit: table select codes
// and the reset-time softplus table for N=16, Q=12, SEGS=8.
package pwl_activation_pipe_pkg;

    localparam int PWL_N    = 16;
    localparam int PWL_Q    = 12;
    localparam int PWL_SEGS = 8;

    typedef enum logic [1:0] {
        TBL_SLOPE = 2'd0,
        TBL_ICPT  = 2'd1,
        TBL_BND   = 2'd2,
        TBL_RSVD  = 2'd3
    } tbl_sel_e;

    // Chord fit of softplus between breakpoints -6.0 .. +6.0 (step 1.5); outer pairs are 0 and identity.
    localparam logic [15:0] DEF_SLOPE [10] = '{
        16'd0, 16'd23, 16'd103, 16'd417, 16'd1343,
        16'd2753, 16'd3679, 16'd3993, 16'd4073, 16'd4096
    };
    localparam logic [15:0] DEF_ICPT [10] = '{
        16'd0, 16'd151, 16'd507, 16'd1451, 16'd2839,
        16'd2839, 16'd1451, 16'd507, 16'd151, 16'd0
    };
    localparam logic [15:0] DEF_BND [9] = '{
        16'hA000, 16'hB800, 16'hD000, 16'hE800, 16'h0000,
        16'h1800, 16'h3000, 16'h4800, 16'h6000
    };

    function automatic logic [15:0] def_entry(input tbl_sel_e sel, input int idx);
        logic [15:0] val;
        val = '0;
        case (sel)
            TBL_SLOPE: if (idx >= 0 && idx < 10) val = DEF_SLOPE[4'(idx)];
            TBL_ICPT:  if (idx >= 0 && idx < 10) val = DEF_ICPT[4'(idx)];
            TBL_BND:   if (idx >= 0 && idx < 9)  val = DEF_BND[4'(idx)];
            default:   val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/pwl_activation_pipe_seg_index.sv
// Segment selector: counts how many breakpoints the sample is at or above.
// Works for any table contents, ordered or not.
module pwl_activation_pipe_seg_index
    import pwl_activation_pipe_pkg::*;
#(
    parameter int N    = PWL_N,
    parameter int SEGS = PWL_SEGS,
    localparam int AW  = $clog2(SEGS + 2)
) (
    input  logic [N-1:0]  x,
    input  logic [N-1:0]  bnd [SEGS+1],
    output logic [AW-1:0] k
);

    localparam int BW = $clog2(SEGS + 1);

    always_comb begin
        k = '0;
        for (int j = 0; j <= SEGS; j++) begin
            if ($signed(x) >= $signed(bnd[BW'(j)])) begin
                k = k + AW'(1);
            end
        end
    end

endmodule

// File: rtl/pwl_activation_pipe.sv
// Pipelined programmable piecewise-linear activation: y = slope[k]*x + icpt[k],
// three registered stages with valid/ready flow control and saturating output.
module pwl_activation_pipe
    import pwl_activation_pipe_pkg::*;
#(
    parameter int N    = PWL_N,
    parameter int Q    = PWL_Q,
    parameter int SEGS = PWL_SEGS,
    localparam int AW  = $clog2(SEGS + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  y,
    output logic          y_sat,
    input  logic          tbl_we,
    input  logic [1:0]    tbl_sel,
    input  logic [AW-1:0] tbl_addr,
    input  logic [N-1:0]  tbl_data
);

    localparam int NE = SEGS + 2;

    logic [N-1:0] slope_tbl [NE];
    logic [N-1:0] icpt_tbl  [NE];
    logic [N-1:0] bnd_tbl   [SEGS+1];
    logic [AW-1:0] k;

    logic                s1_v;
    logic signed [N-1:0] s1_x;
    logic signed [N-1:0] s1_slope;
    logic [N-1:0]        s1_icpt;
    logic                s2_v;
    logic [N:0]          s2_p;
    logic                s2_ovf;
    logic [N-1:0]        s2_icpt;

    logic s1_free, s2_free, s3_free;

    logic signed [2*N-1:0] prod_q;
    logic                  prod_ovf;
    logic [N:0]            prod_clamped;
    logic [N+1:0]          sum;
    logic                  sum_ovf;
    logic [N-1:0]          sum_clip;

    pwl_activation_pipe_seg_index #(.N(N), .SEGS(SEGS)) u_seg_index (
        .x   (x),
        .bnd (bnd_tbl),
        .k   (k)
    );

    // A stage may load when its register is empty or its contents leave this cycle.
    assign s3_free  = !out_valid || out_ready;
    assign s2_free  = !s2_v || s3_free;
    assign s1_free  = !s1_v || s2_free;
    assign in_ready = s1_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                slope_tbl[AW'(i)] <= N'(def_entry(TBL_SLOPE, i));
                icpt_tbl[AW'(i)]  <= N'(def_entry(TBL_ICPT, i));
            end
            for (int i = 0; i <= SEGS; i++) begin
                bnd_tbl[AW'(i)] <= N'(def_entry(TBL_BND, i));
            end
        end else if (tbl_we) begin
            case (tbl_sel_e'(tbl_sel))
                TBL_SLOPE: if (int'(tbl_addr) < NE)    slope_tbl[tbl_addr] <= tbl_data;
                TBL_ICPT:  if (int'(tbl_addr) < NE)    icpt_tbl[tbl_addr]  <= tbl_data;
                TBL_BND:   if (int'(tbl_addr) <= SEGS) bnd_tbl[tbl_addr]   <= tbl_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_x     <= '0;
            s1_slope <= '0;
            s1_icpt  <= '0;
        end else if (s1_free) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_x     <= x;
                s1_slope <= slope_tbl[k];
                s1_icpt  <= icpt_tbl[k];
            end
        end
    end

    // Floor-shifted product; anything outside N+1 bits is pinned so the sum still clips the right way.
    always_comb begin
        prod_q   = ((2*N)'(s1_x) * (2*N)'(s1_slope)) >>> Q;
        prod_ovf = (prod_q[2*N-1:N] != {N{prod_q[N]}});
        if (prod_ovf) begin
            prod_clamped = prod_q[2*N-1] ? {1'b1, {N{1'b0}}} : {1'b0, {N{1'b1}}};
        end else begin
            prod_clamped = prod_q[N:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_p    <= '0;
            s2_ovf  <= 1'b0;
            s2_icpt <= '0;
        end else if (s2_free) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_p    <= prod_clamped;
                s2_ovf  <= prod_ovf;
                s2_icpt <= s1_icpt;
            end
        end
    end

    always_comb begin
        sum     = {s2_p[N], s2_p} + {{2{s2_icpt[N-1]}}, s2_icpt};
        sum_ovf = (sum[N+1:N-1] != {3{sum[N-1]}});
        if (sum_ovf) begin
            sum_clip = sum[N+1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            sum_clip = sum[N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_sat     <= 1'b0;
        end else if (s3_free) begin
            out_valid <= s2_v;
            if (s2_v) begin
                y     <= sum_clip;
                y_sat <= s2_ovf || sum_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Scoreboard bench for pwl_activation_pipe: accepted samples are modelled with plain
// integer arithmetic and queued; a monitor pops and compares every delivered result.
module tb_pwl_activation_pipe;

    localparam int N    = 16;
    localparam int Q    = 12;
    localparam int SEGS = 8;
    localparam int AW   = 4;
    localparam int NE   = SEGS + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  y;
    logic          y_sat;
    logic          tbl_we;
    logic [1:0]    tbl_sel;
    logic [AW-1:0] tbl_addr;
    logic [N-1:0]  tbl_data;

    int     tests_run    = 0;
    int     tests_failed = 0;
    longint cycle_count  = 0;
    bit     check_latency = 1'b0;
    bit     random_ready  = 1'b0;

    logic [N-1:0] m_slope [NE];
    logic [N-1:0] m_icpt  [NE];
    logic [N-1:0] m_bnd   [SEGS+1];

    typedef struct {
        logic [N-1:0] y;
        logic         sat;
        longint       acc_cycle;
    } exp_t;

    exp_t exp_q [$];

    bit           stall_prev = 1'b0;
    logic [N-1:0] held_y;
    logic         held_sat;

    pwl_activation_pipe #(.N(N), .Q(Q), .SEGS(SEGS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_sat     (y_sat),
        .tbl_we    (tbl_we),
        .tbl_sel   (tbl_sel),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    always @(posedge clk) begin
        if (random_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Softplus chords between breakpoints -6.0 .. +6.0 in steps of 1.5, Q12.
    function automatic void load_defaults();
        int s [NE] = '{0, 23, 103, 417, 1343, 2753, 3679, 3993, 4073, 4096};
        int c [NE] = '{0, 151, 507, 1451, 2839, 2839, 1451, 507, 151, 0};
        for (int i = 0; i < NE; i++) begin
            m_slope[4'(i)] = N'(s[4'(i)]);
            m_icpt[4'(i)]  = N'(c[4'(i)]);
        end
        for (int j = 0; j <= SEGS; j++) begin
            m_bnd[4'(j)] = N'(int'((-6.0 + 1.5 * j) * 4096.0));
        end
    endfunction

    function automatic void ref_model(input logic [N-1:0] xv, output exp_t e);
        int     k;
        longint p, pf, s;
        k = 0;
        for (int j = 0; j <= SEGS; j++) begin
            if ($signed(xv) >= $signed(m_bnd[4'(j)])) k++;
        end
        p  = longint'($signed(xv)) * longint'($signed(m_slope[4'(k)]));
        pf = (p - (((p % 4096) + 4096) % 4096)) / 4096;
        s  = pf + longint'($signed(m_icpt[4'(k)]));
        e.acc_cycle = 0;
        if (s > 32767) begin
            e.y = 16'h7FFF;
            e.sat = 1'b1;
        end else if (s < -32768) begin
            e.y = 16'h8000;
            e.sat = 1'b1;
        end else begin
            e.y = N'(s);
            e.sat = 1'b0;
        end
    endfunction

    // Issue side: every accepted sample gets its expectation from the table as it stands
    // before this edge's write, then any table write is applied to the model.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            load_defaults();
        end else begin
            if (in_valid && in_ready) begin
                ref_model(x, e);
                e.acc_cycle = cycle_count;
                exp_q.push_back(e);
            end
            if (tbl_we) begin
                case (tbl_sel)
                    2'd0: if (int'(tbl_addr) < NE)    m_slope[tbl_addr] = tbl_data;
                    2'd1: if (int'(tbl_addr) < NE)    m_icpt[tbl_addr]  = tbl_data;
                    2'd2: if (int'(tbl_addr) <= SEGS) m_bnd[tbl_addr]   = tbl_data;
                    default: ;
                endcase
            end
        end
    end

    task automatic checkOutput();
        exp_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_output: got y=%h sat=%0b, required no output", y, y_sat);
        end else begin
            e = exp_q.pop_front();
            if (y !== e.y || y_sat !== e.sat) begin
                tests_failed++;
                $display("[TB] FAIL result: got y=%h sat=%0b, required y=%h sat=%0b",
                         y, y_sat, e.y, e.sat);
            end
            if (check_latency) begin
                tests_run++;
                if (cycle_count - e.acc_cycle != 3) begin
                    tests_failed++;
                    $display("[TB] FAIL latency: got %0d cycles, required 3",
                             cycle_count - e.acc_cycle);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests_run++;
                if (out_valid !== 1'b1 || y !== held_y || y_sat !== held_sat) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_hold: got v=%0b y=%h sat=%0b, required v=1 y=%h sat=%0b",
                             out_valid, y, y_sat, held_y, held_sat);
                end
            end
            if (out_valid && out_ready) checkOutput();
            stall_prev = out_valid && !out_ready;
            held_y     = y;
            held_sat   = y_sat;
        end
    end

    task automatic checkValue(input string name, input logic [N-1:0] actual, input logic [N-1:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic syncUp();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] xv);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        x = xv;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", waited);
        end
        syncUp();
        in_valid = 1'b0;
    endtask

    task automatic writeTable(input logic [1:0] sel, input int addr, input logic [N-1:0] data);
        tbl_we = 1'b1;
        tbl_sel = sel;
        tbl_addr = AW'(addr);
        tbl_data = data;
        syncUp();
        tbl_we = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
        end
        syncUp();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, required completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        x = '0;
        out_ready = 1'b1;
        tbl_we = 1'b0;
        tbl_sel = '0;
        tbl_addr = '0;
        tbl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkValue("reset_out_valid", N'(out_valid), 16'h0);
        checkValue("reset_y", y, 16'h0);
        checkValue("reset_y_sat", N'(y_sat), 16'h0);
        checkValue("reset_in_ready", N'(in_ready), 16'h1);
        syncUp();

        $display("[TB] default table");
        applyStimulus(16'h0000);
        for (int i = 0; i < 8; i++) applyStimulus(N'($urandom));
        waitDrain();

        $display("[TB] identity");
        for (int i = 0; i < NE; i++) begin
            writeTable(2'd0, i, 16'h1000);
            writeTable(2'd1, i, 16'h0000);
        end
        check_latency = 1'b1;
        applyStimulus(16'h0800);
        applyStimulus(16'hF000);
        applyStimulus(16'h7FFF);
        waitDrain();
        check_latency = 1'b0;

        $display("[TB] segment select");
        for (int i = 0; i < NE; i++) begin
            writeTable(2'd0, i, 16'h0000);
            writeTable(2'd1, i, N'(i << Q));
        end
        applyStimulus(16'hA000);
        applyStimulus(16'h9FFF);
        applyStimulus(16'h6000);
        for (int i = 0; i < 6; i++) applyStimulus(N'($urandom));
        waitDrain();

        $display("[TB] saturation");
        for (int i = 0; i < NE; i++) begin
            writeTable(2'd0, i, 16'h4000);
            writeTable(2'd1, i, 16'h0000);
        end
        applyStimulus(16'h3000);
        applyStimulus(16'hD000);
        applyStimulus(16'h7FFF);
        applyStimulus(16'h8000);
        waitDrain();

        $display("[TB] write/accept collision");
        for (int i = 0; i < NE; i++) begin
            writeTable(2'd0, i, 16'h0000);
            writeTable(2'd1, i, 16'h0200);
        end
        tbl_we = 1'b1;
        tbl_sel = 2'd1;
        tbl_addr = AW'(5);
        tbl_data = 16'h1000;
        applyStimulus(16'h0100);
        tbl_we = 1'b0;
        applyStimulus(16'h0200);
        waitDrain();

        $display("[TB] backpressure");
        for (int i = 0; i < NE; i++) begin
            writeTable(2'd0, i, N'($urandom_range(0, 16'h3000)) ^ (i[0] ? 16'hFFFF : 16'h0000));
            writeTable(2'd1, i, N'($urandom));
        end
        random_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) syncUp();
            if ($urandom_range(0, 9) == 0) begin
                tbl_we = 1'b1;
                tbl_sel = 2'($urandom_range(0, 3));
                tbl_addr = AW'($urandom_range(0, 15));
                tbl_data = N'($urandom);
            end
            applyStimulus(N'($urandom));
            tbl_we = 1'b0;
        end
        waitDrain();
        random_ready = 1'b0;
        syncUp();
        out_ready = 1'b1;

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(16'h1234);
        applyStimulus(16'h2345);
        applyStimulus(16'h3456);
        rst = 1'b1;
        syncUp();
        @(negedge clk);
        checkValue("midreset_out_valid", N'(out_valid), 16'h0);
        checkValue("midreset_y", y, 16'h0);
        syncUp();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) syncUp();
        @(negedge clk);
        checkValue("post_reset_idle", N'(out_valid), 16'h0);
        syncUp();
        applyStimulus(16'h0000);
        applyStimulus(16'h1800);
        applyStimulus(16'hC000);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
